// File: rtl/ac_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator machine.
// Drives PC strobes, the memory handshake, accumulator write and ALU op select.
module ac_control_unit #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic              mem_ack_i,
    input  logic              zero_i,
    input  logic              neg_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic              addr_sel_o,
    output logic [ADDR_W-1:0] op_addr_o,
    output logic              pc_inc_o,
    output logic              jmp_en_o,
    output logic [ADDR_W-1:0] jmp_addr_o,
    output logic              acc_we_o,
    output logic [1:0]        alu_op_o,
    output logic [DATA_W-1:0] ir_o,
    output logic              halted_o,
    output logic              fault_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        RD     = 3'd3,
        WR     = 3'd4,
        JUMP   = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_JMP = 3'b100;
    localparam logic [2:0] OP_JZ  = 3'b101;
    localparam logic [2:0] OP_JN  = 3'b110;

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fault_q, fault_d;
    logic [2:0]         opcode;
    logic               req_state;

    assign opcode     = ir_q[DATA_W-1 -: 3];
    assign op_addr_o  = ir_q[ADDR_W-1:0];
    assign jmp_addr_o = ir_q[ADDR_W-1:0];
    assign ir_o       = ir_q;
    assign halted_o   = (state_q == HALT);
    assign fault_o    = fault_q;
    assign state_o    = state_q;
    assign req_state  = (state_q == FETCH) || (state_q == RD) || (state_q == WR);

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        cnt_d      = cnt_q;
        fault_d    = fault_q;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        addr_sel_o = 1'b0;
        pc_inc_o   = 1'b0;
        jmp_en_o   = 1'b0;
        acc_we_o   = 1'b0;
        alu_op_o   = 2'b00;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ir_d    = instr_i;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                pc_inc_o = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: state_d = RD;
                    OP_STA:                 state_d = WR;
                    OP_JMP:                 state_d = JUMP;
                    OP_JZ:                  state_d = zero_i ? JUMP : FETCH;
                    OP_JN:                  state_d = neg_i  ? JUMP : FETCH;
                    default:                state_d = HALT;
                endcase
            end
            RD: begin
                mem_req_o  = 1'b1;
                addr_sel_o = 1'b1;
                acc_we_o   = mem_ack_i;
                alu_op_o   = (opcode == OP_ADD) ? 2'b01 :
                             (opcode == OP_SUB) ? 2'b10 : 2'b00;
                if (mem_ack_i) state_d = FETCH;
            end
            WR: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                addr_sel_o = 1'b1;
                if (mem_ack_i) state_d = FETCH;
            end
            JUMP: begin
                jmp_en_o = 1'b1;
                state_d  = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        // Ack on the cycle the count would hit the limit still completes normally.
        if (req_state) begin
            if (mem_ack_i) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                state_d = HALT;
                fault_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_ac_control_unit.sv
// Directed bench for ac_control_unit: walks each instruction class, wait states,
// ack timeout, halt and reset priority with hand-computed expectations.
module tb_ac_control_unit;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] instr_i = 8'h00;
    logic       mem_ack_i = 1'b0;
    logic       zero_i = 1'b0;
    logic       neg_i = 1'b0;
    logic       mem_req_o, mem_we_o, addr_sel_o, pc_inc_o, jmp_en_o, acc_we_o;
    logic       halted_o, fault_o;
    logic [4:0] op_addr_o, jmp_addr_o;
    logic [1:0] alu_op_o;
    logic [7:0] ir_o;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_RD = 3,
                            S_WR = 4, S_JUMP = 5, S_HALT = 6;

    ac_control_unit #(.ADDR_W(5), .DATA_W(8), .ACK_TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .mem_ack_i(mem_ack_i),
        .zero_i(zero_i), .neg_i(neg_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .addr_sel_o(addr_sel_o), .op_addr_o(op_addr_o), .pc_inc_o(pc_inc_o),
        .jmp_en_o(jmp_en_o), .jmp_addr_o(jmp_addr_o), .acc_we_o(acc_we_o),
        .alu_op_o(alu_op_o), .ir_o(ir_o), .halted_o(halted_o), .fault_o(fault_o),
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Fetch an instruction with zero-wait ack; leaves the DUT in DECODE.
    task automatic fetch(input logic [7:0] ins);
        instr_i   = ins;
        mem_ack_i = 1'b1;
        chk("in_fetch", 32'(state_o), S_FETCH);
        tick();
        chk("decode", 32'(state_o), S_DECODE);
        chk("decode_pc_inc", 32'(pc_inc_o), 1);
        chk("decode_ir", 32'(ir_o), 32'(ins));
    endtask

    initial begin
        // Reset
        tick(); tick();
        chk("rst_state", 32'(state_o), S_IDLE);
        chk("rst_ir", 32'(ir_o), 0);
        chk("rst_halted", 32'(halted_o), 0);
        chk("rst_fault", 32'(fault_o), 0);
        chk("rst_req", 32'(mem_req_o), 0);
        chk("rst_pc_inc", 32'(pc_inc_o), 0);
        rst_i = 1'b0;
        tick();
        chk("fetch_req", 32'(mem_req_o), 1);
        chk("fetch_sel", 32'(addr_sel_o), 0);

        // LDA 3
        fetch(8'h03);
        chk("lda_op_addr", 32'(op_addr_o), 3);
        tick();
        chk("lda_rd", 32'(state_o), S_RD);
        chk("lda_pc_inc", 32'(pc_inc_o), 0);
        chk("lda_alu", 32'(alu_op_o), 0);
        chk("lda_sel", 32'(addr_sel_o), 1);
        chk("lda_acc_we", 32'(acc_we_o), 1);
        tick();
        chk("lda_acc_we_off", 32'(acc_we_o), 0);

        // ADD / SUB ALU select
        fetch(8'h45); tick();
        chk("add_alu", 32'(alu_op_o), 1);
        tick();
        fetch(8'h66); tick();
        chk("sub_alu", 32'(alu_op_o), 2);
        tick();

        // JMP 25
        fetch(8'h99); tick();
        chk("jmp_state", 32'(state_o), S_JUMP);
        chk("jmp_en", 32'(jmp_en_o), 1);
        chk("jmp_addr", 32'(jmp_addr_o), 25);
        chk("jmp_pc_inc", 32'(pc_inc_o), 0);
        tick();
        chk("jmp_en_off", 32'(jmp_en_o), 0);

        // JZ 4 not taken / taken
        zero_i = 1'b0;
        fetch(8'hA4); tick();
        chk("jz_nt_state", 32'(state_o), S_FETCH);
        chk("jz_nt_jmp", 32'(jmp_en_o), 0);
        zero_i = 1'b1;
        fetch(8'hA4); tick();
        chk("jz_t_jmp", 32'(jmp_en_o), 1);
        chk("jz_t_addr", 32'(jmp_addr_o), 4);
        tick(); zero_i = 1'b0;

        // JN 4 not taken / taken
        neg_i = 1'b0;
        fetch(8'hC4); tick();
        chk("jn_nt_state", 32'(state_o), S_FETCH);
        chk("jn_nt_jmp", 32'(jmp_en_o), 0);
        neg_i = 1'b1;
        fetch(8'hC4); tick();
        chk("jn_t_jmp", 32'(jmp_en_o), 1);
        chk("jn_t_addr", 32'(jmp_addr_o), 4);
        tick(); neg_i = 1'b0;

        // STA 10 with 3 wait states
        fetch(8'h2A);
        mem_ack_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("sta_state", 32'(state_o), S_WR);
            chk("sta_req", 32'(mem_req_o), 1);
            chk("sta_we", 32'(mem_we_o), 1);
            chk("sta_sel", 32'(addr_sel_o), 1);
            if (i == 3) mem_ack_i = 1'b1;
            tick();
        end
        chk("sta_done", 32'(state_o), S_FETCH);

        // HLT; acks ignored
        fetch(8'hE0); tick();
        chk("hlt_state", 32'(state_o), S_HALT);
        chk("hlt_halted", 32'(halted_o), 1);
        chk("hlt_fault", 32'(fault_o), 0);
        chk("hlt_req", 32'(mem_req_o), 0);
        tick();
        chk("hlt_sticky", 32'(state_o), S_HALT);
        rst_i = 1'b1; mem_ack_i = 1'b0;
        tick();
        chk("hlt_rst_state", 32'(state_o), S_IDLE);
        chk("hlt_rst_halted", 32'(halted_o), 0);

        // Timeout: 15 unacked FETCH cycles -> HALT with fault
        rst_i = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("to_still_fetch", 32'(state_o), S_FETCH);
        chk("to_no_fault", 32'(fault_o), 0);
        tick();
        chk("to_state", 32'(state_o), S_HALT);
        chk("to_fault", 32'(fault_o), 1);
        chk("to_halted", 32'(halted_o), 1);
        rst_i = 1'b1;
        tick();
        chk("to_rst_fault", 32'(fault_o), 0);

        // Ack on the 15th cycle wins over the timeout
        rst_i = 1'b0;
        tick();
        for (int i = 0; i < 14; i++) tick();
        fetch(8'h03);
        chk("ackwin_fault", 32'(fault_o), 0);

        // Mid-RD reset with coincident ack
        mem_ack_i = 1'b0;
        tick();
        chk("midrd_state", 32'(state_o), S_RD);
        mem_ack_i = 1'b1; rst_i = 1'b1;
        tick();
        chk("midrd_rst_state", 32'(state_o), S_IDLE);
        chk("midrd_acc_we", 32'(acc_we_o), 0);
        chk("midrd_ir", 32'(ir_o), 0);
        mem_ack_i = 1'b0; rst_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
